// File: rtl/reg_share_arbiter_pkg.sv
// rtl/reg_share_arbiter_pkg.sv - shared types, defaults and round-robin pick for reg_share_arbiter
package reg_share_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Pointer/index width covers the largest supported requester count (8).
  localparam int MAX_N_REQ = 8;
  localparam int PTR_W     = 3;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // First set request scanning ptr, ptr+1, ... modulo n. Iterating from the
  // far end and overwriting leaves the nearest hit in the result.
  function automatic pick_t rr_pick(input logic [MAX_N_REQ-1:0] req,
                                    input logic [PTR_W-1:0]     ptr,
                                    input int                   n);
    pick_t r;
    int    k;
    r = '0;
    for (int i = MAX_N_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (req[k[PTR_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = k[PTR_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// rtl/reg_share_arbiter_if.sv - requester/arbiter bus; lock lane present only under REG_SHARE_LOCK_EN
interface reg_share_if
  import reg_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
`ifdef REG_SHARE_LOCK_EN
  logic [N_REQ-1:0]       lock;
`endif
  logic [N_REQ-1:0]       grant;
  logic [WIDTH-1:0]       q;
  logic                   wr_valid;

`ifdef REG_SHARE_LOCK_EN
  modport master (output req, wdata, lock, input grant, q, wr_valid);
  modport slave  (input req, wdata, lock, output grant, q, wr_valid);
`else
  modport master (output req, wdata, input grant, q, wr_valid);
  modport slave  (input req, wdata, output grant, q, wr_valid);
`endif
endinterface

// File: rtl/reg_share_arbiter_dff.sv
// rtl/reg_share_arbiter_dff.sv - WIDTH-bit enabled D flip-flop register with synchronous reset
module shared_dff_reg
  import reg_share_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset has priority over a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin write arbiter for one shared register; optional REG_SHARE_LOCK_EN
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  reg_share_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [N_REQ-1:0] ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             wr_valid_q, wr_valid_d;

  logic [MAX_N_REQ-1:0] req_ext;
  logic [PTR_W-1:0]     next_ptr;
  logic                 cur_req, cur_lock, at_limit, rel;
  logic                 wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic [WIDTH-1:0]     q_w;
  pick_t                idle_pick, rel_pick;

  // State, grant, pointer and hold counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  // Arbitration, release and write-enable decisions.
  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = bus.req;
    cur_req  = req_ext[gidx_q];
`ifdef REG_SHARE_LOCK_EN
    begin
      logic [MAX_N_REQ-1:0] lock_ext;
      lock_ext = '0;
      lock_ext[N_REQ-1:0] = bus.lock;
      cur_lock = lock_ext[gidx_q];
    end
`else
    cur_lock = 1'b0;
`endif
    at_limit = (hold_q >= HOLD_LAST);
    next_ptr = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
    // The releasing requester sits last in the scan from next_ptr.
    idle_pick = rr_pick(req_ext, ptr_q, N_REQ);
    rel_pick  = rr_pick(req_ext, next_ptr, N_REQ);
    wr_data   = bus.wdata[int'(gidx_q)*WIDTH +: WIDTH];

    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    wr_valid_d = 1'b0;
    wr_en      = 1'b0;
    rel        = 1'b0;

    case (state_q)
      IDLE: begin
        if (idle_pick.found) begin
          state_d = BUSY;
          gidx_d  = idle_pick.idx;
          grant_d = ONE << idle_pick.idx;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (cur_req) begin
          wr_en      = 1'b1;
          wr_valid_d = 1'b1;
          hold_d     = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        end
        rel = !cur_req || (at_limit && !cur_lock);
        if (rel) begin
          ptr_d  = next_ptr;
          hold_d = '0;
          if (rel_pick.found) begin
            gidx_d  = rel_pick.idx;
            grant_d = ONE << rel_pick.idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  shared_dff_reg #(.WIDTH(WIDTH)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (wr_en),
    .d   (wr_data),
    .q   (q_w)
  );

  assign bus.grant    = grant_q;
  assign bus.q        = q_w;
  assign bus.wr_valid = wr_valid_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - directed self-checking bench for reg_share_arbiter
module tb_reg_share_arbiter;
  import reg_share_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  reg_share_if #(.N_REQ(N), .WIDTH(W)) bus ();

  reg_share_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
`ifdef REG_SHARE_LOCK_EN
    bus.lock = '0;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.wdata = 32'h44332211;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant cyc%0d got %b exp 0000", i, bus.grant); end
      checks++;
      if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q cyc%0d got %h exp 00", i, bus.q); end
      checks++;
      if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid cyc%0d got %b exp 0", i, bus.wr_valid); end
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", bus.grant); end
    checks++;
    if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_first_wv got %b exp 0", bus.wr_valid); end
  endtask

  task automatic test_single();
    do_reset();
    bus.wdata = 32'h0000A500;
    bus.req = 4'b0010;
    step();
    checks++;
    if (bus.grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", bus.grant); end
    checks++;
    if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL single_wv_early got %b exp 0", bus.wr_valid); end
    step();
    checks++;
    if (bus.q !== 8'hA5) begin errors++; $display("FAIL single_q got %h exp a5", bus.q); end
    checks++;
    if (bus.wr_valid !== 1'b1) begin errors++; $display("FAIL single_wv got %b exp 1", bus.wr_valid); end
    bus.req = 4'b0000;
    bus.wdata = 32'h0000FF00;
    step();
    checks++;
    if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_drop_grant got %b exp 0000", bus.grant); end
    checks++;
    if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL single_drop_wv got %b exp 0", bus.wr_valid); end
    checks++;
    if (bus.q !== 8'hA5) begin errors++; $display("FAIL single_drop_q got %h exp a5", bus.q); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    int         gi;
    do_reset();
    bus.wdata = 32'h44332211;
    bus.req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      step();
      gi = ((k - 1) / 4) % 4;
      exp_g = 4'b0001 << gi;
      checks++;
      if (bus.grant !== exp_g) begin errors++; $display("FAIL rot_grant edge%0d got %b exp %b", k, bus.grant, exp_g); end
      if (k >= 2) begin
        gi = ((k - 2) / 4) % 4;
        exp_q = 8'(17 * (gi + 1));
        checks++;
        if (bus.q !== exp_q) begin errors++; $display("FAIL rot_q edge%0d got %h exp %h", k, bus.q, exp_q); end
        checks++;
        if (bus.wr_valid !== 1'b1) begin errors++; $display("FAIL rot_wv edge%0d got %b exp 1", k, bus.wr_valid); end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.wdata = 32'h44332211;
    bus.req = 4'b1100;
    step();
    checks++;
    if (bus.grant !== 4'b0100) begin errors++; $display("FAIL wrap_first got %b exp 0100", bus.grant); end
    for (int k = 2; k <= 5; k++) step();
    checks++;
    if (bus.grant !== 4'b1000) begin errors++; $display("FAIL wrap_second got %b exp 1000", bus.grant); end
    bus.req = 4'b0000;
    step();
    checks++;
    if (bus.grant !== 4'b0000) begin errors++; $display("FAIL wrap_idle got %b exp 0000", bus.grant); end
    bus.req = 4'b0011;
    step();
    checks++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL wrap_ptr0 got %b exp 0001", bus.grant); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.wdata = 32'h0000003C;
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    step();
    bus.req = 4'b0001;
    step();
    checks++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL mid_grant got %b exp 0001", bus.grant); end
    step();
    checks++;
    if (bus.q !== 8'h3C) begin errors++; $display("FAIL mid_q got %h exp 3c", bus.q); end
    rst = 1'b1;
    step();
    checks++;
    if (bus.grant !== 4'b0000) begin errors++; $display("FAIL mid_rst_grant got %b exp 0000", bus.grant); end
    checks++;
    if (bus.q !== 8'h00) begin errors++; $display("FAIL mid_rst_q got %h exp 00", bus.q); end
    checks++;
    if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_wv got %b exp 0", bus.wr_valid); end
    rst = 1'b0;
    bus.req = 4'b1001;
    step();
    checks++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL mid_rst_ptr got %b exp 0001", bus.grant); end
  endtask

`ifdef REG_SHARE_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.wdata = 32'h00CC00AA;
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    step();
    bus.req = 4'b0101;
    bus.lock = 4'b0100;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (bus.grant !== 4'b0100) begin errors++; $display("FAIL lock_hold edge%0d got %b exp 0100", k, bus.grant); end
    end
    checks++;
    if (bus.q !== 8'hCC) begin errors++; $display("FAIL lock_q got %h exp cc", bus.q); end
    bus.req = 4'b0001;
    bus.lock = 4'b0000;
    step();
    checks++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL lock_release got %b exp 0001", bus.grant); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.wdata = '0;
`ifdef REG_SHARE_LOCK_EN
    bus.lock = '0;
`endif
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_rst_mid();
`ifdef REG_SHARE_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
